// File: rtl/axi_lite_memory.sv
// AXI4-Lite word-addressed memory with independent read and write channels.
// Define AXI_MEM_RANGE_CHECK_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axi_lite_memory #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddress,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddress,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [1:0]  w_state_dbg,
  output logic        r_state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Readys and valids are functions of FSM state only, never of the opposite side's signals.
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_HAVE_ADDR = 2'd1;
  localparam logic [1:0] W_HAVE_DATA = 2'd2;
  localparam logic [1:0] W_RESP      = 2'd3;
  localparam logic [0:0] R_IDLE      = 1'b0;
  localparam logic [0:0] R_RESP      = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] mem [0:DEPTH-1];

  logic [1:0]  w_state, w_next;
  logic [0:0]  r_state;
  logic [31:0] aw_addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic [31:0] c_addr, c_data, w_off, r_off;
  logic [3:0]  c_strb;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic        w_in_range, r_in_range;

  assign awready = reset && (w_state == W_IDLE || w_state == W_HAVE_DATA);
  assign wready  = reset && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
  assign arready = reset && (r_state == R_IDLE);
  assign bvalid  = (w_state == W_RESP);
  assign rvalid  = (r_state == R_RESP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

  // The committing beat takes whichever half arrives now, the other half from its latch.
  assign c_addr = (w_state == W_HAVE_ADDR) ? aw_addr_q : awaddress;
  assign c_data = (w_state == W_HAVE_DATA) ? wdata_q : wdata;
  assign c_strb = (w_state == W_HAVE_DATA) ? wstrb_q : wstrb;

  assign w_off = c_addr - BASE;
  assign r_off = araddress - BASE;
  assign w_idx = w_off[IDX_W+1:2];
  assign r_idx = r_off[IDX_W+1:2];

`ifdef AXI_MEM_RANGE_CHECK_EN
  assign w_in_range = (w_off < 32'(DEPTH * 4));
  assign r_in_range = (r_off < 32'(DEPTH * 4));
`else
  assign w_in_range = 1'b1;
  assign r_in_range = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, w_off[1:0], r_off[1:0],
                         w_off[31:IDX_W+2], r_off[31:IDX_W+2]};

  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_next = W_RESP;
          commit = 1'b1;
        end else if (aw_hs) begin
          w_next = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_next = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          w_next = W_RESP;
          commit = 1'b1;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          w_next = W_RESP;
          commit = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp     <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_addr_q <= awaddress;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Storage has no reset; contents survive reset pulses.
  always_ff @(posedge clk) begin
    if (commit && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (c_strb[i]) mem[w_idx][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

  // Same-edge read of a word being committed sees the old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= r_in_range ? mem[r_idx] : 32'h0;
            rresp   <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_memory.sv
// Self-checking bench for axi_lite_memory: directed table, corner sequences, random traffic vs model.
module tb_axi_lite_memory;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddress = '0, wdata = '0, araddress = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, r_state_dbg;
  logic [1:0]  bresp, rresp, w_state_dbg;
  logic [31:0] rdata;

  axi_lite_memory #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: flat word array addressed by byte offset from BASE.
  logic [31:0] model_mem [DEPTH];

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    logic [31:0] off;
    int idx;
    off = addr - BASE;
    resp = 2'b00;
`ifdef AXI_MEM_RANGE_CHECK_EN
    if (off >= DEPTH * 4) begin
      resp = 2'b10;
      return;
    end
`endif
    idx = int'((off / 4) % DEPTH);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    logic [31:0] off;
    off = addr - BASE;
    resp = 2'b00;
    data = model_mem[int'((off / 4) % DEPTH)];
`ifdef AXI_MEM_RANGE_CHECK_EN
    if (off >= DEPTH * 4) begin
      resp = 2'b10;
      data = 32'h0;
    end
`endif
  endtask

  // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap delays the later one.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int order, input int gap, input int bdelay, input logic [1:0] exp_resp);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, will_aw, will_w;
    int aw_start, w_start;
    aw_start = (order == 2) ? gap : 0;
    w_start  = (order == 1) ? gap : 0;
    awaddress = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_start);
      wvalid  = !w_done && (cyc >= w_start);
      if (w_done && !aw_done) check("w_first_readys", {awready, wready}, 2'b10);
      if (aw_done && !w_done) check("aw_first_readys", {awready, wready}, 2'b01);
      will_aw = awvalid && awready;
      will_w  = wvalid && wready;
      @(negedge clk);
      aw_done |= will_aw;
      w_done  |= will_w;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check("write_handshake_done", {aw_done, w_done}, 2'b11);
    if (!(aw_done && w_done)) return;
    check("bvalid_after_commit", bvalid, 1'b1);
    check("bresp", bresp, exp_resp);
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      check("b_stall_hold", {bvalid, bresp, awready, wready}, {1'b1, exp_resp, 2'b00});
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("b_done", {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdelay,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int cyc = 0;
    bit done = 0, will_ar;
    araddress = addr;
    while (!done && cyc < 40) begin
      arvalid = 1;
      will_ar = arready;
      @(negedge clk);
      done = will_ar;
      cyc++;
    end
    arvalid = 0;
    check("read_handshake_done", done, 1'b1);
    if (!done) return;
    check("rvalid_latency", rvalid, 1'b1);
    check("rdata", rdata, exp_data);
    check("rresp", rresp, exp_resp);
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      check("r_stall_ctrl", {rvalid, rresp, arready}, {1'b1, exp_resp, 1'b0});
      check("r_stall_data", rdata, exp_data);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check("r_done", {rvalid, arready}, 2'b01);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          order;
    int          gap;
    int          bdelay;
    logic [31:0] raddr;
    int          rdelay;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]  er;
    logic [31:0] ed;
    logic [31:0] a;

    vecs[0] = '{BASE + 8,      32'hDEADBEEF, 4'hF,    0, 0, 0, BASE + 8,      0, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{BASE + 12,     32'h11223344, 4'hF,    0, 0, 0, BASE + 12,     0, 32'h11223344, 2'b00};
    vecs[2] = '{BASE + 12,     32'h000000AA, 4'b0001, 2, 2, 5, BASE + 12,     5, 32'h112233AA, 2'b00};
    vecs[3] = '{BASE + 12,     32'hFFFFFFFF, 4'b0000, 1, 1, 0, BASE + 12,     0, 32'h112233AA, 2'b00};
    vecs[4] = '{BASE + 12,     32'hAABBCCDD, 4'b1010, 1, 3, 2, BASE + 12,     1, 32'hAA22CCAA, 2'b00};
    vecs[5] = '{BASE + 16 + 3, 32'h00005555, 4'hF,    0, 0, 0, BASE + 16,     0, 32'h00005555, 2'b00};
`ifdef AXI_MEM_RANGE_CHECK_EN
    vecs[6] = '{BASE + DEPTH*4, 32'h00000005, 4'hF,   0, 0, 0, BASE + DEPTH*4, 0, 32'h0,       2'b10};
    vecs[7] = '{BASE - 4,      32'h00000077, 4'hF,    2, 1, 0, BASE - 4,      0, 32'h0,        2'b10};
`else
    vecs[6] = '{BASE + DEPTH*4, 32'h00000005, 4'hF,   0, 0, 0, BASE + DEPTH*4, 0, 32'h5,       2'b00};
    vecs[7] = '{BASE - 4,      32'h00000077, 4'hF,    2, 1, 0, BASE - 4,      0, 32'h77,       2'b00};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_readys", {awready, wready, arready}, 3'b000);
    check("reset_valids", {bvalid, rvalid}, 2'b00);
    check("reset_resps", {bresp, rresp}, 4'b0000);
    check("reset_rdata", rdata, 32'h0);
    reset = 1;
    #1;
    check("post_reset_readys", {awready, wready, arready}, 3'b111);
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      model_write(BASE + 4 * i, 32'hA000_0000 + i, 4'hF, er);
      do_write(BASE + 4 * i, 32'hA000_0000 + i, 4'hF, 0, 0, 0, 2'b00);
    end

    for (int v = 0; v < 8; v++) begin
      model_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb, er);
      do_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].order, vecs[v].gap,
               vecs[v].bdelay, vecs[v].exp_resp);
      do_read(vecs[v].raddr, vecs[v].rdelay, vecs[v].exp_rdata, vecs[v].exp_resp);
    end

`ifdef AXI_MEM_RANGE_CHECK_EN
    do_read(BASE, 0, 32'hA000_0000, 2'b00);
    do_read(BASE + 60, 0, 32'hA000_000F, 2'b00);
`else
    do_read(BASE, 0, 32'h0000_0005, 2'b00);
    do_read(BASE + 60, 0, 32'h0000_0077, 2'b00);
`endif

    // Read and write of the same word accepted on one edge
    model_write(BASE + 24, 32'h1, 4'hF, er);
    do_write(BASE + 24, 32'h1, 4'hF, 0, 0, 0, 2'b00);
    awaddress = BASE + 24; wdata = 32'h2; wstrb = 4'hF; araddress = BASE + 24;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("same_edge_rdata_old", rdata, 32'h1);
    check("same_edge_valids", {bvalid, rvalid, bresp, rresp}, 6'b110000);
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    check("same_edge_done", {bvalid, rvalid}, 2'b00);
    model_write(BASE + 24, 32'h2, 4'hF, er);
    do_read(BASE + 24, 0, 32'h2, 2'b00);

    // Reset while holding a write address only
    awaddress = BASE + 20; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    check("have_addr_readys", {awready, wready}, 2'b01);
    #2 reset = 0;
    #1;
    check("mid_reset_outputs", {bvalid, rvalid, awready, wready, arready}, 5'b00000);
    @(negedge clk);
    reset = 1;
    #1;
    check("after_reset_readys", {awready, wready, arready, bvalid}, 4'b1110);
    @(negedge clk);
    model_read(BASE + 20, ed, er);
    do_read(BASE + 20, 0, ed, er);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0)
        a = BASE + DEPTH * 4 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      else
        a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        ed = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        model_write(a, ed, wstrb, er);
        do_write(a, ed, wstrb, $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 3), er);
      end else begin
        model_read(a, ed, er);
        do_read(a, $urandom_range(0, 3), ed, er);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_memory.md
AXI_LITE_MEMORY -- requirements
Module: axi_lite_memory

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 1024, meaning memory size in 32-bit words, which SHALL be a power of two.
REQ-002 The block SHALL expose parameter BASE, default 32'h0000_0000, meaning the byte address of word 0, which SHALL be DEPTH*4 aligned.
REQ-003 The block SHALL expose the following ports (name, direction, width, meaning); one clock; reset is asynchronous and active-low:
  clk  input  1  clock, all state on rising edge
  reset  input  1  asynchronous reset, active-low
  awvalid  input  1  write address valid
  awready  output  1  write address accepted
  awaddress  input  32  write byte address
  awprot  input  3  ignored
  wvalid  input  1  write data valid
  wready  output  1  write data accepted
  wdata  input  32  write data
  wstrb  input  4  byte enables, bit i covers wdata[8i+7:8i]
  bvalid  output  1  write response valid
  bready  input  1  write response accepted
  bresp  output  2  write response, 2'b00 OKAY, 2'b10 SLVERR
  arvalid  input  1  read address valid
  arready  output  1  read address accepted
  araddress  input  32  read byte address
  arprot  input  3  ignored
  rvalid  output  1  read data valid
  rready  input  1  read data accepted
  rdata  output  32  read data
  rresp  output  2  read response, same encoding as bresp

Function
REQ-004 Word index SHALL be (address - BASE) >> 2; address[1:0] SHALL be ignored.
REQ-005 Write FSM SHALL have states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-006 awready SHALL be 1 only in W_IDLE and W_HAVE_DATA; wready SHALL be 1 only in W_IDLE and W_HAVE_ADDR.
REQ-007 In W_IDLE: AW handshake alone -> W_HAVE_ADDR (address latched); W handshake alone -> W_HAVE_DATA (wdata, wstrb latched); both in the same cycle -> W_RESP.
REQ-008 W_HAVE_ADDR on W handshake, and W_HAVE_DATA on AW handshake, SHALL go to W_RESP.
REQ-009 On the edge entering W_RESP, the memory word SHALL be updated only in bytes whose wstrb bit is 1; wstrb=4'b0000 SHALL leave memory unchanged and respond OKAY.
REQ-010 bvalid SHALL be 1 exactly while in W_RESP, with bresp stable; the B handshake (bvalid & bready) SHALL return to W_IDLE.
REQ-011 Read FSM SHALL have states R_IDLE and R_RESP; arready SHALL be 1 only in R_IDLE.
REQ-012 An AR handshake SHALL register rdata/rresp and enter R_RESP; rvalid SHALL rise the following cycle (1-cycle latency).
REQ-013 rvalid, rdata, rresp SHALL hold stable until the R handshake (rvalid & rready), which SHALL return to R_IDLE.
REQ-014 Read and write channels SHALL operate concurrently and independently; at most one outstanding transaction per channel.
REQ-015 A read accepted on the same edge as a write commit to the same word SHALL return the pre-write value.
REQ-016 Valid outputs SHALL NOT depend combinationally on ready inputs.

Reset
REQ-017 While reset=0: all FSMs in IDLE; bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0; awready, wready, arready forced to 0.
REQ-018 Reset asserted mid-transaction SHALL discard latched address/data and any pending response; a write SHALL be committed only if its REQ-009 edge occurred before reset.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 The first rising edge after reset deassertion SHALL present awready=wready=arready=1.

Configuration
REQ-021 With AXI_MEM_RANGE_CHECK_EN defined: address with (address - BASE) >= DEPTH*4 SHALL give SLVERR; writes SHALL be suppressed; reads SHALL return rdata=0.
REQ-022 Without AXI_MEM_RANGE_CHECK_EN: index SHALL wrap modulo DEPTH; responses SHALL always be OKAY.

Verification
REQ-023 AW and W same cycle, addr BASE+8, wdata 32'hDEADBEEF, wstrb 4'hF -> bvalid next cycle, bresp OKAY; then read BASE+8 -> rdata DEADBEEF, rvalid one cycle after AR.
REQ-024 W first (wdata 32'h000000AA, wstrb 4'b0001) over word 32'h11223344, AW two cycles later -> awready stays 1, wready 0 meanwhile; readback 32'h112233AA.
REQ-025 bready and rready held 0 for 5 cycles -> bvalid/rvalid, bresp, rdata stable; awready, wready, arready 0 throughout.
REQ-026 Read and write to the same word on the same edge, old 32'h1, new 32'h2 -> read returns 32'h1; next read returns 32'h2.
REQ-027 Address BASE+DEPTH*4, write 32'h5 -> with AXI_MEM_RANGE_CHECK_EN: bresp 2'b10, word 0 unchanged; without: bresp OKAY, word 0 reads 32'h5.
REQ-028 reset pulsed low while in W_HAVE_ADDR -> bvalid 0, FSM W_IDLE, memory unchanged, readys 1 after deassertion.
